// File: rtl/muldiv_if.sv
// Request/response bundle between the issuing pipeline stage and the iterative mul/div unit.
interface muldiv_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, funct3, rs1, rs2, flush, input busy, done, result);
  modport slave  (input start, funct3, rs1, rs2, flush, output busy, done, result);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiplier/divider: shift-add multiply and restoring division
// on operand magnitudes, one bit per cycle, with sign fix-up in a final cycle.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic     clk,
  input  logic     reset_n,
  muldiv_if.slave  bus
);

  localparam int unsigned CW = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam int unsigned PW = 2 * XLEN;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FINISH} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [2:0]      op, op_nx;
  logic [XLEN-1:0] a_raw, a_nx;
  logic [XLEN-1:0] b_raw, b_nx;
  logic [XLEN-1:0] opnd, opnd_nx;
  logic [PW-1:0]   acc, acc_nx;
  logic            busy_q, busy_nx;
  logic            done_q, done_nx;
  logic [XLEN-1:0] result_q, result_nx;

  function automatic logic sign_a(input logic [2:0] f);
    return !(f == 3'b011 || f == 3'b101 || f == 3'b111);
  endfunction

  function automatic logic sign_b(input logic [2:0] f);
    return (f == 3'b000 || f == 3'b001 || f == 3'b100 || f == 3'b110);
  endfunction

  // Operand magnitudes captured at acceptance
  logic [XLEN-1:0] a_mag_in, b_mag_in;
  assign a_mag_in = (sign_a(bus.funct3) && bus.rs1[XLEN-1]) ? -bus.rs1 : bus.rs1;
  assign b_mag_in = (sign_b(bus.funct3) && bus.rs2[XLEN-1]) ? -bus.rs2 : bus.rs2;

  // acc = {high/remainder, low/quotient}
  logic [XLEN:0]   mul_sum;
  logic [PW-1:0]   mul_step;
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_trial;
  logic [PW-1:0]   div_step;
  assign mul_sum   = {1'b0, acc[PW-1:XLEN]} + (acc[0] ? {1'b0, opnd} : (XLEN+1)'(0));
  assign mul_step  = {mul_sum, acc[XLEN-1:1]};
  assign div_shift = {acc[PW-1:XLEN], acc[XLEN-1]};
  assign div_trial = div_shift - {1'b0, opnd};
  assign div_step  = div_trial[XLEN] ? {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                     : {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};

  // Sign correction and result selection
  logic            prod_neg, quo_neg, rem_neg;
  logic [PW-1:0]   prod_fix;
  logic [XLEN-1:0] quo_fix, rem_fix, final_res;
  assign prod_neg = (sign_a(op) & a_raw[XLEN-1]) ^ (sign_b(op) & b_raw[XLEN-1]);
  assign quo_neg  = prod_neg;
  assign rem_neg  = sign_a(op) & a_raw[XLEN-1];
  assign prod_fix = prod_neg ? -acc : acc;
  assign quo_fix  = quo_neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem_fix  = rem_neg ? -acc[PW-1:XLEN] : acc[PW-1:XLEN];

  always_comb begin
    final_res = prod_fix[XLEN-1:0];
    case (op)
      3'b000:                 final_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod_fix[PW-1:XLEN];
      3'b100, 3'b101:         final_res = quo_fix;
      default:                final_res = rem_fix;
    endcase
  end

  // Division special cases resolved on the first iteration cycle
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] fast_res;
  assign div_zero = (b_raw == '0);
  assign div_ovf  = !op[0] && (a_raw == {1'b1, (XLEN-1)'(0)}) && (b_raw == '1);
  assign fast_res = div_zero ? (op[1] ? a_raw : '1) : (op[1] ? '0 : a_raw);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      op       <= '0;
      a_raw    <= '0;
      b_raw    <= '0;
      opnd     <= '0;
      acc      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      op       <= op_nx;
      a_raw    <= a_nx;
      b_raw    <= b_nx;
      opnd     <= opnd_nx;
      acc      <= acc_nx;
      busy_q   <= busy_nx;
      done_q   <= done_nx;
      result_q <= result_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    op_nx     = op;
    a_nx      = a_raw;
    b_nx      = b_raw;
    opnd_nx   = opnd;
    acc_nx    = acc;
    done_nx   = 1'b0;
    result_nx = result_q;

    case (state)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          op_nx  = bus.funct3;
          a_nx   = bus.rs1;
          b_nx   = bus.rs2;
          cnt_nx = '0;
          if (bus.funct3[2]) begin
            state_nx = DIV;
            acc_nx   = {(XLEN)'(0), a_mag_in};
            opnd_nx  = b_mag_in;
          end else begin
            state_nx = MUL;
            acc_nx   = {(XLEN)'(0), b_mag_in};
            opnd_nx  = a_mag_in;
          end
        end
      end
      MUL: begin
        acc_nx = mul_step;
        cnt_nx = cnt + CW'(1);
        if (cnt == CW'(XLEN - 1)) state_nx = FINISH;
      end
      DIV: begin
        if (cnt == '0 && (div_zero || div_ovf)) begin
          state_nx  = IDLE;
          done_nx   = 1'b1;
          result_nx = fast_res;
        end else begin
          acc_nx = div_step;
          cnt_nx = cnt + CW'(1);
          if (cnt == CW'(XLEN - 1)) state_nx = FINISH;
        end
      end
      FINISH: begin
        state_nx  = IDLE;
        done_nx   = 1'b1;
        result_nx = final_res;
      end
      default: state_nx = IDLE;
    endcase

    // Pipeline kill aborts silently and leaves the last result visible
    if (state != IDLE && bus.flush) begin
      state_nx  = IDLE;
      done_nx   = 1'b0;
      result_nx = result_q;
    end

    busy_nx = (state_nx != IDLE);
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (XLEN=32).
module tb_muldiv_unit;

  localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   pass_cnt = 0;
  int   total = 0;

  muldiv_if #(.XLEN(32)) bus ();

  muldiv_unit #(.XLEN(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  // Issue one request and wait (bounded) for done; lat counts edges from E0, 999 on timeout
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output int busy_cyc);
    bus.funct3 = f; bus.rs1 = a; bus.rs2 = b; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    busy_cyc = bus.busy ? 1 : 0;
    lat = 999;
    res = 'x;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (bus.busy) busy_cyc++;
      if (bus.done) begin
        lat = i;
        res = bus.result;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else pass_cnt++;
    total++; if (bus.done !== 1'b0) $display("FAIL reset_done got=%b exp=0", bus.done); else pass_cnt++;
    total++; if (bus.result !== 32'h0) $display("FAIL reset_result got=%h exp=00000000", bus.result); else pass_cnt++;
    reset_n = 1'b1;
  endtask

  task automatic test_mul();
    logic [31:0] r; int lat; int bc;
    do_op(F_MUL, 32'd2, 32'd2, r, lat, bc);
    total++; if (r !== 32'h4) $display("FAIL mul_2x2 got=%h exp=00000004", r); else pass_cnt++;
    total++; if (lat !== 33) $display("FAIL mul_latency got=%0d exp=33", lat); else pass_cnt++;
    total++; if (bc !== 33) $display("FAIL mul_busy_cycles got=%0d exp=33", bc); else pass_cnt++;
    total++; if (bus.busy !== 1'b0) $display("FAIL mul_busy_at_done got=%b exp=0", bus.busy); else pass_cnt++;
    @(posedge clk); #1;
    total++; if (bus.done !== 1'b0) $display("FAIL mul_done_pulse got=%b exp=0", bus.done); else pass_cnt++;
    total++; if (bus.result !== 32'h4) $display("FAIL mul_result_hold got=%h exp=00000004", bus.result); else pass_cnt++;
    do_op(F_MUL, 32'hFFFF_FFFD, 32'd5, r, lat, bc);
    total++; if (r !== 32'hFFFF_FFF1) $display("FAIL mul_neg got=%h exp=fffffff1", r); else pass_cnt++;
    do_op(F_MUL, 32'h0001_0003, 32'h0002_0005, r, lat, bc);
    total++; if (r !== 32'h000B_000F) $display("FAIL mul_wrap got=%h exp=000b000f", r); else pass_cnt++;
  endtask

  task automatic test_mulh();
    logic [31:0] r; int lat; int bc;
    do_op(F_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat, bc);
    total++; if (r !== 32'h0) $display("FAIL mulh got=%h exp=00000000", r); else pass_cnt++;
    do_op(F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat, bc);
    total++; if (r !== 32'hFFFF_FFFE) $display("FAIL mulhu got=%h exp=fffffffe", r); else pass_cnt++;
    do_op(F_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, r, lat, bc);
    total++; if (r !== 32'hFFFF_FFFF) $display("FAIL mulhsu got=%h exp=ffffffff", r); else pass_cnt++;
    do_op(F_MULH, 32'h8000_0000, 32'h8000_0000, r, lat, bc);
    total++; if (r !== 32'h4000_0000) $display("FAIL mulh_min got=%h exp=40000000", r); else pass_cnt++;
    total++; if (lat !== 33) $display("FAIL mulh_latency got=%0d exp=33", lat); else pass_cnt++;
  endtask

  task automatic test_div();
    logic [31:0] r; int lat; int bc;
    do_op(F_DIV, 32'd7, 32'hFFFF_FFFE, r, lat, bc);
    total++; if (r !== 32'hFFFF_FFFD) $display("FAIL div_7_m2 got=%h exp=fffffffd", r); else pass_cnt++;
    total++; if (lat !== 33) $display("FAIL div_latency got=%0d exp=33", lat); else pass_cnt++;
    do_op(F_REM, 32'd7, 32'hFFFF_FFFE, r, lat, bc);
    total++; if (r !== 32'h1) $display("FAIL rem_7_m2 got=%h exp=00000001", r); else pass_cnt++;
    do_op(F_DIVU, 32'd7, 32'd2, r, lat, bc);
    total++; if (r !== 32'h3) $display("FAIL divu_7_2 got=%h exp=00000003", r); else pass_cnt++;
    do_op(F_REMU, 32'd7, 32'd2, r, lat, bc);
    total++; if (r !== 32'h1) $display("FAIL remu_7_2 got=%h exp=00000001", r); else pass_cnt++;
    do_op(F_DIV, 32'hFFFF_FFF9, 32'd2, r, lat, bc);
    total++; if (r !== 32'hFFFF_FFFD) $display("FAIL div_m7_2 got=%h exp=fffffffd", r); else pass_cnt++;
    do_op(F_REM, 32'hFFFF_FFF9, 32'd2, r, lat, bc);
    total++; if (r !== 32'hFFFF_FFFF) $display("FAIL rem_m7_2 got=%h exp=ffffffff", r); else pass_cnt++;
    do_op(F_DIVU, 32'hFFFF_FFFF, 32'd16, r, lat, bc);
    total++; if (r !== 32'h0FFF_FFFF) $display("FAIL divu_big got=%h exp=0fffffff", r); else pass_cnt++;
  endtask

  task automatic test_fast_path();
    logic [31:0] r; int lat; int bc;
    do_op(F_DIVU, 32'd5, 32'd0, r, lat, bc);
    total++; if (r !== 32'hFFFF_FFFF) $display("FAIL divu_by0 got=%h exp=ffffffff", r); else pass_cnt++;
    total++; if (lat !== 1) $display("FAIL divu_by0_latency got=%0d exp=1", lat); else pass_cnt++;
    do_op(F_REMU, 32'd5, 32'd0, r, lat, bc);
    total++; if (r !== 32'h5) $display("FAIL remu_by0 got=%h exp=00000005", r); else pass_cnt++;
    total++; if (lat !== 1) $display("FAIL remu_by0_latency got=%0d exp=1", lat); else pass_cnt++;
    do_op(F_REM, 32'hFFFF_FFFB, 32'd0, r, lat, bc);
    total++; if (r !== 32'hFFFF_FFFB) $display("FAIL rem_by0_neg got=%h exp=fffffffb", r); else pass_cnt++;
    do_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, bc);
    total++; if (r !== 32'h8000_0000) $display("FAIL div_ovf got=%h exp=80000000", r); else pass_cnt++;
    total++; if (lat !== 1) $display("FAIL div_ovf_latency got=%0d exp=1", lat); else pass_cnt++;
    do_op(F_REM, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, bc);
    total++; if (r !== 32'h0) $display("FAIL rem_ovf got=%h exp=00000000", r); else pass_cnt++;
    do_op(F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, bc);
    total++; if (r !== 32'h0) $display("FAIL divu_no_ovf got=%h exp=00000000", r); else pass_cnt++;
    total++; if (lat !== 33) $display("FAIL divu_no_ovf_latency got=%0d exp=33", lat); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] r; int lat; int bc;
    do_op(F_DIVU, 32'd100, 32'd9, r, lat, bc);
    total++; if (r !== 32'd11) $display("FAIL b2b_first got=%h exp=0000000b", r); else pass_cnt++;
    // Issued in the done cycle: the next edge must be accepted as E0
    do_op(F_MUL, 32'd6, 32'd7, r, lat, bc);
    total++; if (r !== 32'd42) $display("FAIL b2b_second got=%h exp=0000002a", r); else pass_cnt++;
    total++; if (lat !== 33) $display("FAIL b2b_latency got=%0d exp=33", lat); else pass_cnt++;
  endtask

  task automatic test_busy_start_and_flush();
    int lat; bit saw_done;
    // Start pulse while busy must not disturb the running DIVU 100/7
    bus.funct3 = F_DIVU; bus.rs1 = 32'd100; bus.rs2 = 32'd7; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1 bus.funct3 = F_MULHU; bus.rs1 = 32'd1; bus.rs2 = 32'd1; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    lat = 999;
    for (int i = 6; i <= 100; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin lat = i; break; end
    end
    total++; if (lat !== 33) $display("FAIL ignore_start_latency got=%0d exp=33", lat); else pass_cnt++;
    total++; if (bus.result !== 32'd14) $display("FAIL ignore_start_result got=%h exp=0000000e", bus.result); else pass_cnt++;

    // Flush after iteration 10
    @(posedge clk); #1;
    bus.funct3 = F_MULHU; bus.rs1 = 32'h1234_5678; bus.rs2 = 32'h9ABC_DEF0; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    total++; if (bus.busy !== 1'b1) $display("FAIL flush_pre_busy got=%b exp=1", bus.busy); else pass_cnt++;
    bus.flush = 1'b1;
    @(posedge clk); #1 bus.flush = 1'b0;
    total++; if (bus.busy !== 1'b0) $display("FAIL flush_busy got=%b exp=0", bus.busy); else pass_cnt++;
    total++; if (bus.done !== 1'b0) $display("FAIL flush_done got=%b exp=0", bus.done); else pass_cnt++;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done) saw_done = 1'b1;
    end
    total++; if (saw_done !== 1'b0) $display("FAIL flush_no_done got=%b exp=0", saw_done); else pass_cnt++;
    total++; if (bus.result !== 32'd14) $display("FAIL flush_result_hold got=%h exp=0000000e", bus.result); else pass_cnt++;

    // Flush and start together in IDLE: request dropped
    bus.funct3 = F_MUL; bus.rs1 = 32'd9; bus.rs2 = 32'd9; bus.start = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0; bus.flush = 1'b0;
    total++; if (bus.busy !== 1'b0) $display("FAIL flush_vs_start_busy got=%b exp=0", bus.busy); else pass_cnt++;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    total++; if (saw_done !== 1'b0) $display("FAIL flush_vs_start_activity got=%b exp=0", saw_done); else pass_cnt++;
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] r; int lat; int bc; bit saw_done;
    bus.funct3 = F_MUL; bus.rs1 = 32'h1234; bus.rs2 = 32'h10; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (20) @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk); #1;
    total++; if (bus.busy !== 1'b0) $display("FAIL midreset_busy got=%b exp=0", bus.busy); else pass_cnt++;
    total++; if (bus.done !== 1'b0) $display("FAIL midreset_done got=%b exp=0", bus.done); else pass_cnt++;
    total++; if (bus.result !== 32'h0) $display("FAIL midreset_result got=%h exp=00000000", bus.result); else pass_cnt++;
    reset_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done) saw_done = 1'b1;
    end
    total++; if (saw_done !== 1'b0) $display("FAIL midreset_no_done got=%b exp=0", saw_done); else pass_cnt++;
    do_op(F_MUL, 32'd3, 32'd5, r, lat, bc);
    total++; if (r !== 32'hF) $display("FAIL midreset_mul got=%h exp=0000000f", r); else pass_cnt++;
    total++; if (lat !== 33) $display("FAIL midreset_mul_latency got=%0d exp=33", lat); else pass_cnt++;
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.flush  = 1'b0;
    bus.funct3 = 3'b000;
    bus.rs1    = '0;
    bus.rs2    = '0;
    @(negedge clk);
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_fast_path();
    test_back_to_back();
    test_busy_start_and_flush();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
